// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller.
// Divider sequencer state encoding and stage control bundle.
package pipeline_ctrl_pkg;

   localparam int DIV_CYCLES_DEF = 32;
   localparam int CNTW = 6;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic stall_e;
      logic stall_m;
      logic stall_w;
      logic flush_d;
      logic flush_e;
      logic flush_m;
      logic flush_w;
      logic pc_exc;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the datapath and stage controls back to it.
// master = datapath side, slave = controller side.
interface pipeline_ctrl_if #(
   parameter int REGW = 5
);
   logic [REGW-1:0] id_rs;
   logic [REGW-1:0] id_rt;
   logic            id_branch;
   logic [REGW-1:0] ex_wreg;
   logic            ex_regwrite;
   logic            ex_memtoreg;
   logic [REGW-1:0] mem_wreg;
   logic            mem_memtoreg;
   logic            ex_div_start;
   logic            mem_except;
   logic            i_stall;
   logic            d_stall;

   logic stallF, stallD, stallE, stallM, stallW;
   logic flushD, flushE, flushM, flushW;
   logic pc_sel_except;
   logic div_busy;
   logic div_done;

   modport master (
      output id_rs, id_rt, id_branch,
      output ex_wreg, ex_regwrite, ex_memtoreg,
      output mem_wreg, mem_memtoreg,
      output ex_div_start, mem_except,
      output i_stall, d_stall,
      input  stallF, stallD, stallE, stallM, stallW,
      input  flushD, flushE, flushM, flushW,
      input  pc_sel_except, div_busy, div_done
   );

   modport slave (
      input  id_rs, id_rt, id_branch,
      input  ex_wreg, ex_regwrite, ex_memtoreg,
      input  mem_wreg, mem_memtoreg,
      input  ex_div_start, mem_except,
      input  i_stall, d_stall,
      output stallF, stallD, stallE, stallM, stallW,
      output flushD, flushE, flushM, flushW,
      output pc_sel_except, div_busy, div_done
   );

endinterface

// File: rtl/pipeline_ctrl_div_seq.sv
// Iterative divider sequencer: holds the div in EX for DIV_CYCLES+1
// cycles, free-running through bus waits, aborted by an applied flush.
module pipeline_ctrl_div_seq
   import pipeline_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   input  logic bus_stall,
   input  logic exc,
   output logic div_stall,
   output logic div_busy,
   output logic div_done
);

   localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(DIV_CYCLES - 1);

   div_state_t      state;
   logic [CNTW-1:0] cnt;
   logic            flush_now;

   assign flush_now = exc & ~bus_stall;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (flush_now) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && !exc) begin
                  state <= DIV_RUN;
                  cnt   <= CNT_LOAD;
               end
            end
            DIV_RUN: begin
               if (cnt == '0)
                  state <= DIV_DONE;
               else
                  cnt <= cnt - 1'b1;
            end
            // hold until the pipe moves so EX keeps the result
            DIV_DONE: begin
               if (!bus_stall)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign div_busy  = (state == DIV_RUN);
   assign div_done  = (state == DIV_DONE);
   assign div_stall = ((state == IDLE) & start) | div_busy;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/stall controller for the five-stage pipeline.
// Priority: bus wait > exception > divide > load-use/branch hazard.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int REGW       = 5
) (
   input logic           clk,
   input logic           resetn,
   pipeline_ctrl_if.slave bus
);

   localparam logic [REGW-1:0] R0 = '0;

   logic  bus_stall;
   logic  exc;
   logic  except_pending;
   logic  ex_hit;
   logic  mem_hit;
   logic  lwstall;
   logic  brstall;
   logic  div_stall;
   logic  div_busy;
   logic  div_done;
   ctrl_t c;

   assign bus_stall = bus.i_stall | bus.d_stall;
   assign exc       = bus.mem_except | except_pending;

   assign ex_hit  = (bus.ex_wreg != R0) &
                    ((bus.ex_wreg == bus.id_rs) |
                     (bus.ex_wreg == bus.id_rt));
   assign mem_hit = (bus.mem_wreg != R0) &
                    ((bus.mem_wreg == bus.id_rs) |
                     (bus.mem_wreg == bus.id_rt));

   assign lwstall = bus.ex_memtoreg & bus.ex_regwrite & ex_hit;
   assign brstall = bus.id_branch &
                    ((bus.ex_regwrite & ex_hit) |
                     (bus.mem_memtoreg & mem_hit));

   pipeline_ctrl_div_seq #(
      .DIV_CYCLES(DIV_CYCLES)
   ) u_div (
      .clk      (clk),
      .resetn   (resetn),
      .start    (bus.ex_div_start),
      .bus_stall(bus_stall),
      .exc      (exc),
      .div_stall(div_stall),
      .div_busy (div_busy),
      .div_done (div_done)
   );

   // an exception seen during a bus wait is replayed once the bus frees
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         except_pending <= 1'b0;
      else if (bus_stall) begin
         if (bus.mem_except)
            except_pending <= 1'b1;
      end else if (exc)
         except_pending <= 1'b0;
   end

   always_comb begin
      c = CTRL_NONE;
      if (bus_stall) begin
         c.stall_f = 1'b1;
         c.stall_d = 1'b1;
         c.stall_e = 1'b1;
         c.stall_m = 1'b1;
         c.stall_w = 1'b1;
      end else if (exc) begin
         c.flush_d = 1'b1;
         c.flush_e = 1'b1;
         c.flush_m = 1'b1;
         c.flush_w = 1'b1;
         c.pc_exc  = 1'b1;
      end else if (div_stall) begin
         c.stall_f = 1'b1;
         c.stall_d = 1'b1;
         c.stall_e = 1'b1;
         c.flush_m = 1'b1;
      end else if (lwstall | brstall) begin
         c.stall_f = 1'b1;
         c.stall_d = 1'b1;
         c.flush_e = 1'b1;
      end
   end

   assign bus.stallF        = c.stall_f;
   assign bus.stallD        = c.stall_d;
   assign bus.stallE        = c.stall_e;
   assign bus.stallM        = c.stall_m;
   assign bus.stallW        = c.stall_w;
   assign bus.flushD        = c.flush_d;
   assign bus.flushE        = c.flush_e;
   assign bus.flushM        = c.flush_m;
   assign bus.flushW        = c.flush_w;
   assign bus.pc_sel_except = c.pc_exc;
   assign bus.div_busy      = div_busy;
   assign bus.div_done      = div_done;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues expected outputs,
// negedge monitor pops and compares one entry per cycle.
module tb_pipeline_ctrl;

   // {stallF,D,E,M,W, flushD,E,M,W, pc_sel_except, div_busy, div_done}
   localparam logic [11:0] ZERO = 12'b0000_0000_0000;
   localparam logic [11:0] HAZ  = 12'b1100_0010_0000;
   localparam logic [11:0] DIVS = 12'b1110_0001_0000;
   localparam logic [11:0] BUSY = 12'b0000_0000_0010;
   localparam logic [11:0] DONE = 12'b0000_0000_0001;
   localparam logic [11:0] BUS  = 12'b1111_1000_0000;
   localparam logic [11:0] EXC  = 12'b0000_0111_1100;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   always #5 clk = ~clk;

   pipeline_ctrl_if #(.REGW(5)) bus ();

   pipeline_ctrl #(
      .DIV_CYCLES(32),
      .REGW      (5)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   typedef struct {
      logic [11:0] exp;
      string       nm;
   } item_t;

   item_t q[$];
   int tests = 0;
   int fails = 0;

   function automatic logic [11:0] obs();
      return {bus.stallF, bus.stallD, bus.stallE, bus.stallM,
              bus.stallW, bus.flushD, bus.flushE, bus.flushM,
              bus.flushW, bus.pc_sel_except, bus.div_busy,
              bus.div_done};
   endfunction

   always @(negedge clk) begin
      item_t it;
      if (q.size() != 0) begin
         it = q.pop_front();
         tests++;
         if (obs() !== it.exp) begin
            fails++;
            $display("FAIL %s: got %b want %b", it.nm, obs(), it.exp);
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_(input logic [11:0] e, input string nm);
      item_t it;
      it.exp = e;
      it.nm  = nm;
      q.push_back(it);
   endtask

   task automatic clr();
      bus.id_rs        = '0;
      bus.id_rt        = '0;
      bus.id_branch    = 1'b0;
      bus.ex_wreg      = '0;
      bus.ex_regwrite  = 1'b0;
      bus.ex_memtoreg  = 1'b0;
      bus.mem_wreg     = '0;
      bus.mem_memtoreg = 1'b0;
      bus.ex_div_start = 1'b0;
      bus.mem_except   = 1'b0;
      bus.i_stall      = 1'b0;
      bus.d_stall      = 1'b0;
   endtask

   // start pulse then n DIV_RUN cycles (cnt 31 down)
   task automatic div_start_run(input int n, input string tag);
      next();
      bus.ex_div_start = 1'b1;
      exp_(DIVS, {tag, " start"});
      for (int i = 0; i < n; i++) begin
         next();
         bus.ex_div_start = 1'b0;
         exp_(DIVS | BUSY, {tag, " run"});
      end
   endtask

   initial begin
      clr();
      resetn = 1'b0;
      next();
      exp_(ZERO, "reset");
      next();
      exp_(ZERO, "reset hold");
      next();
      resetn = 1'b1;
      exp_(ZERO, "after reset");

      // load-use
      next();
      bus.ex_memtoreg = 1'b1;
      bus.ex_regwrite = 1'b1;
      bus.ex_wreg = 5'd8;
      bus.id_rs = 5'd8;
      exp_(HAZ, "lw rs");
      next();
      bus.ex_wreg = 5'd0;
      exp_(ZERO, "lw r0 wreg");
      next();
      bus.id_rs = 5'd0;
      exp_(ZERO, "lw r0 both");
      next();
      bus.ex_wreg = 5'd8;
      bus.id_rt = 5'd8;
      exp_(HAZ, "lw rt");
      next();
      bus.ex_regwrite = 1'b0;
      exp_(ZERO, "lw no regwrite");
      next();
      bus.ex_regwrite = 1'b1;
      bus.d_stall = 1'b1;
      exp_(BUS, "bus over lw");
      next();
      clr();
      exp_(ZERO, "idle");

      // branch hazards
      next();
      bus.id_branch = 1'b1;
      bus.mem_memtoreg = 1'b1;
      bus.mem_wreg = 5'd9;
      bus.id_rt = 5'd9;
      exp_(HAZ, "br mem load");
      next();
      bus.id_branch = 1'b0;
      exp_(ZERO, "br dropped");
      next();
      clr();
      bus.id_branch = 1'b1;
      bus.ex_regwrite = 1'b1;
      bus.ex_wreg = 5'd3;
      bus.id_rs = 5'd3;
      exp_(HAZ, "br ex alu");
      next();
      bus.id_branch = 1'b0;
      exp_(ZERO, "alu no branch");
      next();
      clr();
      exp_(ZERO, "idle");

      // direct exception, and exception beats divide start
      next();
      bus.mem_except = 1'b1;
      exp_(EXC, "exc direct");
      next();
      bus.mem_except = 1'b0;
      exp_(ZERO, "exc one shot");
      next();
      bus.mem_except = 1'b1;
      bus.ex_div_start = 1'b1;
      exp_(EXC, "exc over div");
      next();
      clr();
      exp_(ZERO, "div not started");

      // full divide
      div_start_run(32, "div");
      next();
      exp_(DONE, "div done");
      next();
      exp_(ZERO, "div idle");

      // bus wait while in DIV_DONE
      div_start_run(32, "div2");
      for (int i = 0; i < 3; i++) begin
         next();
         bus.d_stall = 1'b1;
         exp_(BUS | DONE, "done held");
      end
      next();
      bus.d_stall = 1'b0;
      exp_(DONE, "done release");
      next();
      exp_(ZERO, "div2 idle");

      // deferred exception
      next();
      bus.i_stall = 1'b1;
      bus.mem_except = 1'b1;
      exp_(BUS, "defer latch");
      for (int i = 0; i < 3; i++) begin
         next();
         bus.mem_except = 1'b0;
         exp_(BUS, "defer hold");
      end
      next();
      bus.i_stall = 1'b0;
      exp_(EXC, "defer flush");
      next();
      exp_(ZERO, "defer cleared");

      // exception under bus wait aborts a running divide
      div_start_run(5, "div3");
      next();
      bus.i_stall = 1'b1;
      bus.mem_except = 1'b1;
      exp_(BUS | BUSY, "div exc wait");
      next();
      bus.mem_except = 1'b0;
      exp_(BUS | BUSY, "div exc wait2");
      next();
      bus.i_stall = 1'b0;
      exp_(EXC | BUSY, "div exc flush");
      next();
      exp_(ZERO, "div aborted");

      // reset at cnt==10, then a full divide again
      div_start_run(21, "div4");
      next();
      resetn = 1'b0;
      exp_(ZERO, "reset mid div");
      next();
      exp_(ZERO, "reset mid hold");
      next();
      resetn = 1'b1;
      exp_(ZERO, "reset released");
      div_start_run(32, "div5");
      next();
      exp_(DONE, "div5 done");
      next();
      exp_(ZERO, "div5 idle");

      for (int i = 0; i < 10 && q.size() != 0; i++)
         @(posedge clk);
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d left want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard/stall controller for the five-stage MIPS pipeline. It drives the per-stage stall (enable = ~stall) and flush (clear) inputs of the F/D, D/E, E/M and M/W pipeline registers and the PC register. It also sequences the iterative divider and defers exception flushes that arrive while a bus wait is in progress. Sits beside the datapath; consumes hazard info from ID/EX/MEM and stall requests from the instruction and data bus bridges.

Parameters:
DIV_CYCLES, 32, EX-stage cycles the iterative divider needs before its result is valid (2..63)
REGW, 5, register-index width

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
id_rs  in  REGW  ID source reg 1
id_rt  in  REGW  ID source reg 2
id_branch  in  1  ID holds branch/jr needing operands in ID
ex_wreg  in  REGW  EX destination reg
ex_regwrite  in  1  EX writes register
ex_memtoreg  in  1  EX is a load
mem_wreg  in  REGW  MEM destination reg
mem_memtoreg  in  1  MEM is a load
ex_div_start  in  1  EX holds div/divu
mem_except  in  1  exception detected in MEM (1-cycle pulse)
i_stall  in  1  instruction bus wait
d_stall  in  1  data bus wait
stallF, stallD, stallE, stallM, stallW  out  1 each  hold PC / stage registers
flushD, flushE, flushM, flushW  out  1 each  clear stage registers
pc_sel_except  out  1  select exception vector for PC
div_busy  out  1  divider running
div_done  out  1  divider result valid this cycle

Behaviour:
- State machine: IDLE, DIV_RUN, DIV_DONE; 6-bit down-counter cnt; 1-bit except_pending.
- Reset: state=IDLE, cnt=0, except_pending=0. Outputs during and after reset with all inputs 0: every stall/flush=0, pc_sel_except=0, div_busy=0, div_done=0.
- Terms: bus_stall = i_stall|d_stall. exc = mem_except|except_pending. Register matches ignore index 0.
- lwstall = ex_memtoreg & ex_regwrite & (ex_wreg==id_rs | ex_wreg==id_rt).
- brstall = id_branch & ((ex_regwrite & ex_wreg matches rs/rt) | (mem_memtoreg & mem_wreg matches rs/rt)).
- div_stall = (state==IDLE & ex_div_start) | state==DIV_RUN.
- Output priority, highest first; all unlisted outputs are 0:
  1. bus_stall: all five stalls=1, no flush. If mem_except, set except_pending.
  2. exc: flushD/E/M/W=1, pc_sel_except=1, clear except_pending, force state=IDLE (aborts divide).
  3. div_stall: stallF/D/E=1, flushM=1 (bubble into MEM).
  4. lwstall|brstall: stallF/D=1, flushE=1.
  5. Otherwise all 0.
- FSM transitions:
  - IDLE -> DIV_RUN when ex_div_start & ~exc. Load cnt=DIV_CYCLES-1.
  - DIV_RUN: cnt decrements every cycle, including during bus_stall (divider free-runs). At cnt==0, go to DIV_DONE.
  - DIV_DONE: div_done=1, no div stall. Leave to IDLE when ~bus_stall. Otherwise hold, so EX retains the result until the pipe moves.
  - A DIV_DONE cycle with ex_div_start still high does not restart the divider. IDLE is entered only after the instruction advances.
- div_busy = (state==DIV_RUN).
- Exception during DIV_RUN with bus_stall: pending is latched; divider keeps counting until the flush applies, then state goes to IDLE.
- Latency: lwstall/brstall/div stall are combinational in the same cycle. Divide occupies EX for DIV_CYCLES+1 cycles. A deferred exception flushes in the first cycle with bus_stall=0.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, DIV_RUN=2'd1, DIV_DONE=2'd2) and the DIV_CYCLES default.
- One natural sub-module: div_seq (FSM + counter, outputs div_stall/div_busy/div_done). The priority mux stays in pipeline_ctrl.

Test Plan:
- Load-use: ex_memtoreg=1, ex_regwrite=1, ex_wreg=8, id_rs=8 -> stallF=stallD=flushE=1 for exactly that cycle; with ex_wreg=0, all outputs 0.
- Branch hazard: id_branch=1, mem_memtoreg=1, mem_wreg=9, id_rt=9 -> stallF/D=1, flushE=1; drop id_branch -> all 0.
- Divide: ex_div_start pulse in IDLE, DIV_CYCLES=32 -> stallF/D/E=1 and flushM=1 for 33 cycles (1 IDLE + 32 DIV_RUN), div_busy=1 for 32 cycles, then div_done=1 for one cycle with no stall.
- Bus stall in DIV_DONE: d_stall=1 when DIV_DONE is entered, held 3 cycles -> div_done stays 1 and all stalls=1 for 3 cycles, then IDLE.
- Deferred exception: i_stall=1, mem_except pulse, i_stall released 4 cycles later -> no flush while stalled; in the release cycle flushD/E/M/W=1 and pc_sel_except=1 for one cycle; except_pending then 0.
- Reset mid-divide: assert resetn=0 at cnt=10 -> immediately div_busy=0 and all stalls/flushes 0; after release, a new ex_div_start runs a full 32-cycle divide.
